vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator, the successor to the fixed 640x480 scrolling-stripe demo top. It has its own H/V timing counters with configurable porches, sync widths and sync polarity. It produces one of four patterns at a configurable colour depth, with frame-synchronous scroll control (speed, direction, pause). It feeds the TinyVGA PMOD packing at chip top, or any wider DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, 0 = active-low syncs, 1 = active-high
COLOR_W, 2, bits per colour channel (1..4)
CNT_W, 10, width of position counters and scroll offset

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  pattern select, sampled at frame boundary
speed  in  4  scroll step per frame, sampled at frame boundary
dir  in  1  0 = offset increments, 1 = offset decrements; sampled at frame boundary
pause  in  1  1 = hold offset; sampled at frame boundary
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
display_on  out  1  high while the output pixel is in the active area
hpos  out  CNT_W  horizontal counter (registered)
vpos  out  CNT_W  vertical counter (registered)
r, g, b  out  COLOR_W each  colour; all zero when display_on is low
frame_start  out  1  one-cycle pulse when counters wrap to (0,0)
offset  out  CNT_W  current scroll offset

Behaviour:
- Reset (async assert, sync release): hpos=vpos=0, offset=0; shadow mode/speed/dir/pause = 0; display_on=0, r=g=b=0, frame_start=0; hsync/vsync at inactive level (1 if SYNC_POL=0).
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- hpos increments every clk and wraps H_TOTAL-1 -> 0. On that wrap, vpos increments, wrapping V_TOTAL-1 -> 0.
- Frame boundary = the edge where (hpos,vpos) goes (H_TOTAL-1, V_TOTAL-1) -> (0,0). On that edge:
  - frame_start is registered high for exactly that one cycle. It never fires at reset release.
  - Shadow registers load mode, speed, dir and pause. Inputs have no effect at any other time.
  - offset updates from the previous shadow values: unchanged if pause=1; else offset+speed (dir=0) or offset-speed (dir=1), modulo 2^CNT_W.
- All colour and sync outputs are registered from the current counters and shadow state. They therefore lag hpos/vpos by exactly 1 cycle.
  - display_on = (hpos<H_ACTIVE) && (vpos<V_ACTIVE).
  - hsync is active when H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active when V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, for the whole line.
- Patterns use mx = hpos+offset and my = vpos+offset (CNT_W bits, wrapping). Bit indices above CNT_W-1 read 0.
  - mode 0, stripes: r=mx[5 +: COLOR_W], g=mx[6 +: COLOR_W], b=vpos[5 +: COLOR_W].
  - mode 1, checker: all channels = {COLOR_W{mx[5]^vpos[5]}}.
  - mode 2, bars: k=mx[8:6]; r=all ones if k[0], g=all ones if k[1], b=all ones if k[2]; otherwise 0.
  - mode 3, gradient: r=g=b=my[8 -: COLOR_W].
- Outside the active area, r=g=b=0 regardless of mode.

Optional Feature:
VGA_PATTERN_BORDER_EN
- Defined: an active pixel with hpos==0, hpos==H_ACTIVE-1, vpos==0 or vpos==V_ACTIVE-1 outputs r=g=b=all ones, overriding every mode. Same 1-cycle latency as the pattern.
- Undefined: no override logic; output is the pattern only.

Test Plan:
1. Defaults, 2 frames -> hsync low for exactly 96 clks every 800 clks; vsync low for exactly 2 lines (1600 clks) every 525 lines; display_on high 640 of 800 clks on lines 0..479.
2. SYNC_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=8, V_FP=1, V_SYNC=1, V_BP=2 -> hsync high for hpos 18..20 (seen one cycle later); frame_start pulses every 24*12=288 clks; no pulse at reset release.
3. speed=3, dir=0, pause=0 held -> offset reads 0 after frame 1, then 3, 6, 9. Switch to dir=1 mid-frame -> offset does not change before the next frame_start; it reads 6 after the frame that sampled dir=1.
4. offset=2^CNT_W-2, speed=5, dir=0 -> offset wraps to 3. pause=1 -> offset is held across 3 frames.
5. mode 2, offset 0, COLOR_W=2 -> pixels 0..63 give r=g=b=0; pixels 64..127 give r=3, g=b=0; pixels 448..511 give r=g=b=3; r=g=b=0 during blanking.
6. rst_n pulsed low mid-line -> all outputs go to reset values immediately, without waiting for clk. After release, counting restarts at (0,0). With VGA_PATTERN_BORDER_EN defined, mode 1 pixel (0,5) outputs all ones.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA timing and test-pattern generator. It has free-running H/V position
//   counters with configurable porches, sync widths and sync polarity. It
//   produces one of four test patterns with a frame-synchronous scroll offset.
//   All sync and colour outputs are registered, so they lag hpos/vpos by one
//   clock.
//
//   Optional build macro: VGA_PATTERN_BORDER_EN
//     When defined, the outermost active rows and columns are forced to full
//     white, overriding every pattern.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   mode         pattern select (0 stripes, 1 checker, 2 bars, 3 gradient)
//   speed        scroll step per frame
//   dir          0 = offset counts up, 1 = offset counts down
//   pause        1 = hold offset
//   hsync/vsync  syncs, polarity set by SYNC_POL
//   display_on   output pixel lies in the active area
//   hpos/vpos    position counters
//   r/g/b        colour channels, zero outside the active area
//   frame_start  one-cycle pulse when the counters wrap to (0,0)
//   offset       current scroll offset
//
//   mode, speed, dir and pause are only sampled on the frame boundary.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 2,
  parameter int CNT_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [3:0]         speed,
  input  logic               dir,
  input  logic               pause,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start,
  output logic [CNT_W-1:0]   offset
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             SYNC_ON    = (SYNC_POL != 0);

  logic [1:0]         sh_mode;
  logic [3:0]         sh_speed;
  logic               sh_dir;
  logic               sh_pause;

  logic               h_end;
  logic               frame_end;
  logic               active;
  logic               hs_act;
  logic               vs_act;
  logic [CNT_W-1:0]   mx;
  logic [CNT_W-1:0]   my;
  logic [CNT_W-1:0]   step;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] pat_r;
  logic [COLOR_W-1:0] pat_g;
  logic [COLOR_W-1:0] pat_b;

  // Bit select that reads 0 beyond the counter width, so pattern bit
  // positions stay legal for narrow CNT_W / wide COLOR_W combinations.
  function automatic logic bit_at(input logic [CNT_W-1:0] v, input int idx);
    bit_at = 1'b0;
    for (int k = 0; k < CNT_W; k++) begin
      if (k == idx) bit_at = v[k];
    end
  endfunction

  always_comb begin
    h_end     = (hpos == H_LAST);
    frame_end = h_end && (vpos == V_LAST);
    active    = (hpos < H_ACT) && (vpos < V_ACT);
    hs_act    = (hpos >= H_SYNC_LO) && (hpos < H_SYNC_HI);
    vs_act    = (vpos >= V_SYNC_LO) && (vpos < V_SYNC_HI);
    mx        = hpos + offset;
    my        = vpos + offset;
    step      = CNT_W'(sh_speed);

    bar = '0;
    for (int j = 0; j < 3; j++) bar[j] = bit_at(mx, 6 + j);

    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (sh_mode)
      2'd0: begin
        for (int i = 0; i < COLOR_W; i++) begin
          pat_r[i] = bit_at(mx, 5 + i);
          pat_g[i] = bit_at(mx, 6 + i);
          pat_b[i] = bit_at(vpos, 5 + i);
        end
      end
      2'd1: begin
        pat_r = {COLOR_W{bit_at(mx, 5) ^ bit_at(vpos, 5)}};
        pat_g = pat_r;
        pat_b = pat_r;
      end
      2'd2: begin
        pat_r = {COLOR_W{bar[0]}};
        pat_g = {COLOR_W{bar[1]}};
        pat_b = {COLOR_W{bar[2]}};
      end
      default: begin
        // Top COLOR_W bits ending at my[8].
        for (int i = 0; i < COLOR_W; i++) pat_r[i] = bit_at(my, 9 - COLOR_W + i);
        pat_g = pat_r;
        pat_b = pat_r;
      end
    endcase

`ifdef VGA_PATTERN_BORDER_EN
    // Only reaches the outputs for active pixels; blanking zeroes it below.
    if ((hpos == '0) || (hpos == H_ACT - CNT_ONE) ||
        (vpos == '0) || (vpos == V_ACT - CNT_ONE)) begin
      pat_r = '1;
      pat_g = '1;
      pat_b = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      offset      <= '0;
      sh_mode     <= '0;
      sh_speed    <= '0;
      sh_dir      <= 1'b0;
      sh_pause    <= 1'b0;
      frame_start <= 1'b0;
      display_on  <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      if (h_end) begin
        hpos <= '0;
        vpos <= (vpos == V_LAST) ? '0 : vpos + CNT_ONE;
      end else begin
        hpos <= hpos + CNT_ONE;
      end

      frame_start <= frame_end;

      // The offset moves with the settings captured at the previous boundary.
      // The new settings are captured on this same edge.
      if (frame_end) begin
        if (!sh_pause) offset <= sh_dir ? offset - step : offset + step;
        sh_mode  <= mode;
        sh_speed <= speed;
        sh_dir   <= dir;
        sh_pause <= pause;
      end

      display_on <= active;
      hsync      <= hs_act ? SYNC_ON : ~SYNC_ON;
      vsync      <= vs_act ? SYNC_ON : ~SYNC_ON;
      r          <= active ? pat_r : '0;
      g          <= active ? pat_g : '0;
      b          <= active ? pat_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen.
// dut_a: default horizontal timing with a short 8-line frame.
// dut_b: tiny 24x12 frame with active-high syncs.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [1:0] a_mode, b_mode;
  logic [3:0] a_speed, b_speed;
  logic       a_dir, b_dir, a_pause, b_pause;

  logic       a_hsync, a_vsync, a_de, a_fs;
  logic [9:0] a_hpos, a_vpos, a_offset;
  logic [1:0] a_r, a_g, a_b;

  logic       b_hsync, b_vsync, b_de, b_fs;
  logic [9:0] b_hpos, b_vpos, b_offset;
  logic [1:0] b_r, b_g, b_b;

  int checks = 0;
  int failures = 0;

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [5:0] BORDER_RGB = 6'h3f;
`else
  localparam logic [5:0] BORDER_RGB = 6'h00;
`endif

  vga_pattern_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .mode(a_mode), .speed(a_speed), .dir(a_dir), .pause(a_pause),
    .hsync(a_hsync), .vsync(a_vsync), .display_on(a_de),
    .hpos(a_hpos), .vpos(a_vpos),
    .r(a_r), .g(a_g), .b(a_b),
    .frame_start(a_fs), .offset(a_offset)
  );

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mode(b_mode), .speed(b_speed), .dir(b_dir), .pause(b_pause),
    .hsync(b_hsync), .vsync(b_vsync), .display_on(b_de),
    .hpos(b_hpos), .vpos(b_vpos),
    .r(b_r), .g(b_g), .b(b_b),
    .frame_start(b_fs), .offset(b_offset)
  );

  // Leaves the bench on a falling edge with reset just released:
  // no rising edge has been seen since release yet.
  task automatic do_reset();
    rst_n = 1'b0;
    a_mode = 0; a_speed = 0; a_dir = 0; a_pause = 0;
    b_mode = 0; b_speed = 0; b_dir = 0; b_pause = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fs_a();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (a_fs === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      failures++;
      $display("FAIL wait_fs_a timeout got=no_pulse exp=pulse");
    end
  endtask

  task automatic wait_fs_b();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b_fs === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      failures++;
      $display("FAIL wait_fs_b timeout got=no_pulse exp=pulse");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_mode = 0; a_speed = 0; a_dir = 0; a_pause = 0;
    b_mode = 0; b_speed = 0; b_dir = 0; b_pause = 0;
    repeat (2) @(negedge clk);
    checks++; if (a_hpos !== 10'd0) begin failures++; $display("FAIL rst_hpos got=%0d exp=0", a_hpos); end
    checks++; if (a_vpos !== 10'd0) begin failures++; $display("FAIL rst_vpos got=%0d exp=0", a_vpos); end
    checks++; if (a_offset !== 10'd0) begin failures++; $display("FAIL rst_offset got=%0d exp=0", a_offset); end
    checks++; if (a_de !== 1'b0) begin failures++; $display("FAIL rst_de got=%b exp=0", a_de); end
    checks++; if ({a_r, a_g, a_b} !== 6'd0) begin failures++; $display("FAIL rst_rgb got=%h exp=0", {a_r, a_g, a_b}); end
    checks++; if (a_fs !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", a_fs); end
    checks++; if ({a_hsync, a_vsync} !== 2'b11) begin failures++; $display("FAIL rst_sync_lowpol got=%b exp=11", {a_hsync, a_vsync}); end
    checks++; if ({b_hsync, b_vsync} !== 2'b00) begin failures++; $display("FAIL rst_sync_highpol got=%b exp=00", {b_hsync, b_vsync}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (b_fs !== 1'b0) begin failures++; $display("FAIL release_fs got=%b exp=0", b_fs); end
    checks++; if (b_hpos !== 10'd1) begin failures++; $display("FAIL release_hpos got=%0d exp=1", b_hpos); end
  endtask

  // 800 clks per line, 8 lines per frame, two frames.
  task automatic test_sync_default();
    int hs_low, vs_low, de_cnt, run, bad_run, hfalls, vfalls, bad_gap;
    int first_hfall, last_hfall, first_vfall;
    logic prev_hs, prev_vs;
    hs_low = 0; vs_low = 0; de_cnt = 0; run = 0; bad_run = 0;
    hfalls = 0; vfalls = 0; bad_gap = 0;
    first_hfall = -1; last_hfall = -1; first_vfall = -1;
    do_reset();
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int c = 1; c <= 12800; c++) begin
      @(negedge clk);
      if (!a_hsync) begin hs_low++; run++; end
      else begin
        if (run != 0 && run != 96) bad_run++;
        run = 0;
      end
      if (prev_hs && !a_hsync) begin
        hfalls++;
        if (first_hfall < 0) first_hfall = c;
        if (last_hfall >= 0 && c - last_hfall != 800) bad_gap++;
        last_hfall = c;
      end
      if (prev_vs && !a_vsync) begin
        vfalls++;
        if (first_vfall < 0) first_vfall = c;
      end
      if (!a_vsync) vs_low++;
      if (a_de) de_cnt++;
      prev_hs = a_hsync;
      prev_vs = a_vsync;
    end
    checks++; if (hs_low != 1536) begin failures++; $display("FAIL def_hsync_low got=%0d exp=1536", hs_low); end
    checks++; if (bad_run != 0) begin failures++; $display("FAIL def_hsync_width bad_runs=%0d exp=0", bad_run); end
    checks++; if (hfalls != 16 || bad_gap != 0) begin failures++; $display("FAIL def_hsync_period falls=%0d bad_gaps=%0d exp=16/0", hfalls, bad_gap); end
    checks++; if (first_hfall != 657) begin failures++; $display("FAIL def_hsync_first got=%0d exp=657", first_hfall); end
    checks++; if (vs_low != 3200 || vfalls != 2) begin failures++; $display("FAIL def_vsync low=%0d falls=%0d exp=3200/2", vs_low, vfalls); end
    checks++; if (first_vfall != 4001) begin failures++; $display("FAIL def_vsync_first got=%0d exp=4001", first_vfall); end
    checks++; if (de_cnt != 5120) begin failures++; $display("FAIL def_display_on got=%0d exp=5120", de_cnt); end
  endtask

  // 24x12 frame, active-high syncs.
  task automatic test_small_timing();
    int hs_err, vs_err, de_err, fs_cnt, first_fs, pos, hp, vp;
    logic e_hs, e_vs, e_de;
    hs_err = 0; vs_err = 0; de_err = 0; fs_cnt = 0; first_fs = -1;
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      pos = c - 1;
      hp = pos % 24;
      vp = (pos / 24) % 12;
      e_hs = (hp >= 18 && hp <= 20);
      e_vs = (vp == 9);
      e_de = (hp < 16 && vp < 8);
      if (b_hsync !== e_hs) hs_err++;
      if (b_vsync !== e_vs) vs_err++;
      if (b_de !== e_de) de_err++;
      if (b_fs === 1'b1) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = c;
      end
    end
    checks++; if (hs_err != 0) begin failures++; $display("FAIL small_hsync errs=%0d exp=0", hs_err); end
    checks++; if (vs_err != 0) begin failures++; $display("FAIL small_vsync errs=%0d exp=0", vs_err); end
    checks++; if (de_err != 0) begin failures++; $display("FAIL small_display_on errs=%0d exp=0", de_err); end
    checks++; if (first_fs != 288) begin failures++; $display("FAIL small_fs_first got=%0d exp=288", first_fs); end
    checks++; if (fs_cnt != 2) begin failures++; $display("FAIL small_fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_scroll();
    do_reset();
    b_speed = 4'd3; b_dir = 1'b0; b_pause = 1'b0;
    wait_fs_b();
    checks++; if (b_offset !== 10'd0) begin failures++; $display("FAIL scroll_f1 got=%0d exp=0", b_offset); end
    wait_fs_b();
    checks++; if (b_offset !== 10'd3) begin failures++; $display("FAIL scroll_f2 got=%0d exp=3", b_offset); end
    wait_fs_b();
    checks++; if (b_offset !== 10'd6) begin failures++; $display("FAIL scroll_f3 got=%0d exp=6", b_offset); end
    repeat (100) @(negedge clk);
    b_dir = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (b_offset !== 10'd6) begin failures++; $display("FAIL scroll_midframe got=%0d exp=6", b_offset); end
    wait_fs_b();
    checks++; if (b_offset !== 10'd9) begin failures++; $display("FAIL scroll_f4 got=%0d exp=9", b_offset); end
    wait_fs_b();
    checks++; if (b_offset !== 10'd6) begin failures++; $display("FAIL scroll_dir_f5 got=%0d exp=6", b_offset); end
  endtask

  task automatic test_wrap_pause();
    do_reset();
    b_speed = 4'd2; b_dir = 1'b1;
    wait_fs_b();
    b_speed = 4'd5; b_dir = 1'b0;
    wait_fs_b();
    checks++; if (b_offset !== 10'd1022) begin failures++; $display("FAIL wrap_pre got=%0d exp=1022", b_offset); end
    wait_fs_b();
    checks++; if (b_offset !== 10'd3) begin failures++; $display("FAIL wrap_up got=%0d exp=3", b_offset); end
    b_pause = 1'b1;
    wait_fs_b();
    checks++; if (b_offset !== 10'd8) begin failures++; $display("FAIL pause_last_step got=%0d exp=8", b_offset); end
    for (int f = 0; f < 3; f++) begin
      wait_fs_b();
      checks++; if (b_offset !== 10'd8) begin failures++; $display("FAIL pause_hold%0d got=%0d exp=8", f, b_offset); end
    end
  endtask

  task automatic test_gradient();
    do_reset();
    b_mode = 2'd3; b_speed = 4'd15; b_dir = 1'b1;
    wait_fs_b();
    wait_fs_b();
    checks++; if (b_offset !== 10'd1009) begin failures++; $display("FAIL grad_offset got=%0d exp=1009", b_offset); end
    // pixel (5,2): my = 1011, my[8:7] = 3
    repeat (54) @(negedge clk);
    checks++; if ({b_r, b_g, b_b} !== 6'h3f) begin failures++; $display("FAIL grad_px got=%h exp=3f", {b_r, b_g, b_b}); end
  endtask

  task automatic test_bars();
    int px[11];
    logic [5:0] ex[11];
    int p;
    px = '{0, 63, 64, 127, 200, 448, 511, 512, 639, 640, 799};
    ex = '{6'b000000, 6'b000000, 6'b110000, 6'b110000, 6'b111100, 6'b111111,
           6'b111111, 6'b000000, 6'b110000, 6'b000000, 6'b000000};
    do_reset();
    a_mode = 2'd2;
    wait_fs_a();
    for (int j = 1; j <= 800; j++) begin
      @(negedge clk);
      p = j - 1;
      for (int t = 0; t < 11; t++) begin
        if (p == px[t]) begin
          checks++;
          if ({a_r, a_g, a_b} !== ex[t]) begin
            failures++;
            $display("FAIL bars_px%0d got=%b exp=%b", p, {a_r, a_g, a_b}, ex[t]);
          end
        end
      end
    end
  endtask

  // Runs straight after test_bars: dut_a is at the start of line 1 in mode 2.
  task automatic test_async_reset();
    repeat (101) @(negedge clk);
    checks++; if ({a_de, a_r} !== 3'b111) begin failures++; $display("FAIL pre_reset_px got=%b exp=111", {a_de, a_r}); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_hpos !== 10'd0 || a_vpos !== 10'd0) begin failures++; $display("FAIL async_pos got=%0d,%0d exp=0,0", a_hpos, a_vpos); end
    checks++; if ({a_de, a_r, a_g, a_b} !== 7'd0) begin failures++; $display("FAIL async_pixel got=%b exp=0", {a_de, a_r, a_g, a_b}); end
    checks++; if ({a_hsync, a_vsync, a_fs} !== 3'b110) begin failures++; $display("FAIL async_sync got=%b exp=110", {a_hsync, a_vsync, a_fs}); end
    checks++; if ({b_hsync, b_vsync} !== 2'b00) begin failures++; $display("FAIL async_sync_b got=%b exp=00", {b_hsync, b_vsync}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (a_hpos !== 10'd5 || a_vpos !== 10'd0) begin failures++; $display("FAIL restart_pos got=%0d,%0d exp=5,0", a_hpos, a_vpos); end
  endtask

  task automatic test_stripes_checker();
    do_reset();
    a_mode = 2'd0;
    wait_fs_a();
    repeat (97) @(negedge clk);   // pixel 96
    checks++; if ({a_r, a_g, a_b} !== 6'b110100) begin failures++; $display("FAIL stripes_px96 got=%b exp=110100", {a_r, a_g, a_b}); end
    repeat (104) @(negedge clk);  // pixel 200
    checks++; if ({a_r, a_g, a_b} !== 6'b101100) begin failures++; $display("FAIL stripes_px200 got=%b exp=101100", {a_r, a_g, a_b}); end
    a_mode = 2'd1;
    wait_fs_a();
    repeat (33) @(negedge clk);   // pixel 32
    checks++; if ({a_r, a_g, a_b} !== 6'b111111) begin failures++; $display("FAIL checker_px32 got=%b exp=111111", {a_r, a_g, a_b}); end
    repeat (32) @(negedge clk);   // pixel 64
    checks++; if ({a_r, a_g, a_b} !== 6'b000000) begin failures++; $display("FAIL checker_px64 got=%b exp=000000", {a_r, a_g, a_b}); end
  endtask

  task automatic test_border();
    do_reset();
    b_mode = 2'd1;
    wait_fs_b();
    repeat (121) @(negedge clk);  // pixel (0,5)
    checks++; if (b_de !== 1'b1) begin failures++; $display("FAIL border_de got=%b exp=1", b_de); end
    checks++; if ({b_r, b_g, b_b} !== BORDER_RGB) begin failures++; $display("FAIL border_px0_5 got=%h exp=%h", {b_r, b_g, b_b}, BORDER_RGB); end
    repeat (3) @(negedge clk);    // pixel (3,5)
    checks++; if ({b_r, b_g, b_b} !== 6'h00) begin failures++; $display("FAIL border_px3_5 got=%h exp=00", {b_r, b_g, b_b}); end
  endtask

  initial begin
    test_reset();
    test_sync_default();
    test_small_timing();
    test_scroll();
    test_wrap_pause();
    test_gradient();
    test_bars();
    test_async_reset();
    test_stripes_checker();
    test_border();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
